// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider with borrow-lookahead trial subtractor
// Also holds the lookahead subtractor used for each trial subtraction.

module borrow_lookahead_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-2:0] o_diff,
  output logic         o_borrow
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N-2:0] w_c;
  logic         w_cout;

  // a - b computed as a + ~b + 1, so the carry into bit 0 is always 1.
  assign w_g = i_a & ~i_b;
  assign w_p = i_a ^ ~i_b;

  // Flattened lookahead: carry into bit k from all lower generate/propagate terms.
  function automatic logic carry_into(input logic [N-1:0] g, input logic [N-1:0] p, input int k);
    logic acc;
    logic prod;
    acc  = 1'b0;
    prod = 1'b1;
    for (int j = N - 1; j >= 0; j--) begin
      if (j < k) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
    end
    return acc | prod;
  endfunction

  always_comb begin
    w_c = '0;
    for (int i = 0; i < N - 1; i++) begin
      w_c[i] = carry_into(w_g, w_p, i);
    end
    w_cout = carry_into(w_g, w_p, N);
  end

  // The top difference bit is never needed: a trial that fits is below the divisor.
  assign o_diff   = w_p[N-2:0] ^ w_c;
  assign o_borrow = ~w_cout;

endmodule

module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_div_zero;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_t;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_div_zero = (i_divisor == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (r_count == LAST_STEP) begin
          w_last       = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Shift the next dividend bit into the partial remainder, then try the subtraction.
  assign w_s = {r_rem, r_q[WIDTH-1]};

  borrow_lookahead_sub #(
    .N(WIDTH + 1)
  ) u_sub (
    .i_a     (w_s),
    .i_b     ({1'b0, r_divisor}),
    .o_diff  (w_t),
    .o_borrow(w_borrow)
  );

  assign w_rem_next = w_borrow ? w_s[WIDTH-1:0] : w_t;
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_q       <= i_dividend;
      r_divisor <= i_divisor;
      if (w_div_zero) begin
        r_quotient  <= '1;
        r_remainder <= i_dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_dbz <= 1'b0;
      end
    end else if (w_step) begin
      r_count <= r_count + CW'(1);
      r_rem   <= w_rem_next;
      r_q     <= w_q_next;
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_rem_next;
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule
